// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt pending controller slice:
//   - NUM_IRQ / IRQ_ID_W : request-line count and encoded id width (8:3)
//   - irq_state_e        : handshake FSM states
//   - IRQ_ID_RESET       : value of irq_id out of reset
//   - id_to_onehot()     : expands an encoded id into a per-line clear vector
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_IRQ  = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } irq_state_e;

    localparam logic [IRQ_ID_W-1:0] IRQ_ID_RESET = 3'b000;

    // One-hot expansion of an interrupt id, used to clear a serviced pending bit.
    function automatic logic [NUM_IRQ-1:0] id_to_onehot(input logic [IRQ_ID_W-1:0] id);
        logic [NUM_IRQ-1:0] vec;
        vec     = {NUM_IRQ{1'b0}};
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Single request line: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector. The 'set' output is the per-line set request into the pending
// register.
//   Build option IRQ_LEVEL_EN: when defined, 'set' is the synchronised level
//   taken one stage early (the pending register then acts as the final
//   synchroniser stage), so the edge detector is bypassed.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   req    in  asynchronous request line, active-high
//   set    out edge pulse (default) or synchronised level (IRQ_LEVEL_EN)
// -----------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic set
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Synchroniser shift chain; bit 0 samples the asynchronous request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req};
        end
    end

`ifdef IRQ_LEVEL_EN
    // Level mode: the pending flop downstream completes the synchroniser,
    // which is what buys back the cycle of latency.
    assign set = sync_r[SYNC_STAGES-2];
`else
    logic sync_d_r;

    // Delayed copy of the synchronised level for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d_r <= 1'b0;
        end else begin
            sync_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign set = sync_r[SYNC_STAGES-1] & ~sync_d_r;
`endif

endmodule

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
// Upstream feeder for the 8:3 priority encoder. Synchronises eight request
// lines, latches rising edges into 'pending', presents pending & irq_mask to
// the encoder and captures the encoder result into a held irq_id, served to
// the consumer through an irq_valid / irq_ack handshake.
//   Build option IRQ_LEVEL_EN: level-sensitive mode. Pending follows the
//   synchronised request level and an ack completes the handshake without
//   clearing pending (the source must drop its request).
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   irq_req    in   [7:0] asynchronous request lines
//   irq_mask   in   [7:0] per-line enable toward the encoder
//   enc_in     out  [7:0] encoder 'in' = pending & irq_mask (combinational)
//   enc_en     out  encoder 'en' = |enc_in (combinational)
//   enc_op     in   [2:0] encoder result, highest set index of enc_in
//   irq_valid  out  interrupt presented to the consumer
//   irq_id     out  [2:0] presented interrupt index, stable while irq_valid
//   irq_ack    in   consumer acknowledge pulse
//   pending    out  [7:0] raw pending register
// -----------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    output logic [NUM_IRQ-1:0]  enc_in,
    output logic                enc_en,
    input  logic [IRQ_ID_W-1:0] enc_op,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_ack,
    output logic [NUM_IRQ-1:0]  pending
);

    logic [NUM_IRQ-1:0]  set_s;
    logic [NUM_IRQ-1:0]  clr_vec_s;
    logic [NUM_IRQ-1:0]  pending_next_s;
    logic [NUM_IRQ-1:0]  pending_r;
    irq_state_e          state_r;
    irq_state_e          next_state_s;
    logic                irq_valid_r;
    logic                valid_next_s;
    logic [IRQ_ID_W-1:0] irq_id_r;
    logic [IRQ_ID_W-1:0] id_next_s;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (irq_req[gi]),
            .set   (set_s[gi])
        );
    end

    // Next pending vector; a new set on the bit being acked wins over the clear.
    always_comb begin
        pending_next_s = {NUM_IRQ{1'b0}};
`ifdef IRQ_LEVEL_EN
        pending_next_s = set_s;
`else
        pending_next_s = (pending_r & ~clr_vec_s) | set_s;
`endif
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_IRQ{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign enc_in  = pending_r & irq_mask;
    assign enc_en  = |enc_in;
    assign pending = pending_r;

    // Handshake FSM next-state and output decode. Once BUSY the captured id is
    // held: later pends or mask changes never preempt it.
    always_comb begin
        next_state_s = state_r;
        valid_next_s = irq_valid_r;
        id_next_s    = irq_id_r;
        clr_vec_s    = {NUM_IRQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (enc_en) begin
                    id_next_s    = enc_op;
                    valid_next_s = 1'b1;
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (irq_ack) begin
                    clr_vec_s    = id_to_onehot(irq_id_r);
                    valid_next_s = 1'b0;
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DRAIN: begin
                // Lets the encoder settle on the cleared pending vector.
                valid_next_s = 1'b0;
                next_state_s = IDLE;
            end
            default: begin
                valid_next_s = 1'b0;
                id_next_s    = IRQ_ID_RESET;
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            irq_valid_r <= 1'b0;
            irq_id_r    <= IRQ_ID_RESET;
        end else begin
            state_r     <= next_state_s;
            irq_valid_r <= valid_next_s;
            irq_id_r    <= id_next_s;
        end
    end

    assign irq_valid = irq_valid_r;
    assign irq_id    = irq_id_r;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Closed-loop bench: irq_pending_ctrl driving a behavioural 8:3 priority
// encoder. A cycle-level reference model built from the request history
// predicts pending, encoder inputs and the presented interrupt every cycle.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_req;
    logic [7:0] irq_mask;
    logic [7:0] enc_in;
    logic       enc_en;
    logic [2:0] enc_op;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pending;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_id;
    logic       m_drain;
    logic [7:0] h1, h2, h3;   // irq_req as sampled 1, 2 and 3 edges ago

    irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_req   (irq_req),
        .irq_mask  (irq_mask),
        .enc_in    (enc_in),
        .enc_en    (enc_en),
        .enc_op    (enc_op),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending)
    );

    // Stand-in for the existing priority encoder: highest set bit wins.
    always_comb begin
        enc_op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (enc_in[i]) enc_op = i[2:0];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_id    = 3'd0;
        m_drain = 1'b0;
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
    endtask

    // Advance the model across one rising edge using the inputs in force there.
    task automatic model_edge();
        logic [7:0] old_p, clr, nxt;
        old_p = m_pend;
        clr   = 8'h00;
        if (m_valid && irq_ack) clr[m_id] = 1'b1;
`ifdef IRQ_LEVEL_EN
        nxt = h1;
`else
        nxt = (old_p & ~clr) | (h2 & ~h3);
`endif
        if (m_valid) begin
            if (irq_ack) begin
                m_valid = 1'b0;
                m_drain = 1'b1;
            end
        end else if (m_drain) begin
            m_drain = 1'b0;
        end else if ((old_p & irq_mask) != 8'h00) begin
            m_valid = 1'b1;
            m_id    = highest(old_p & irq_mask);
        end
        m_pend = nxt;
        h3 = h2; h2 = h1; h1 = irq_req;
    endtask

    task automatic compare_all();
        check("pending",   pending,             m_pend);
        check("enc_in",    enc_in,              m_pend & irq_mask);
        check("enc_en",    {7'd0, enc_en},      {7'd0, |(m_pend & irq_mask)});
        check("irq_valid", {7'd0, irq_valid},   {7'd0, m_valid});
        check("irq_id",    {5'd0, irq_id},      {5'd0, m_id});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] r;
        rst_n    = 1'b0;
        irq_req  = 8'h00;
        irq_mask = 8'hFF;
        irq_ack  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pending", pending, 8'h00);
        check("rst_valid",   {7'd0, irq_valid}, 8'h00);
        check("rst_id",      {5'd0, irq_id},    8'h00);
        check("rst_enc_en",  {7'd0, enc_en},    8'h00);
        rst_n = 1'b1;

`ifndef IRQ_LEVEL_EN
        // Single line 5: pending at k+2, presented at k+3, cleared by ack.
        irq_req = 8'h20; tick(); irq_req = 8'h00;
        tick();
        tick();
        check("t1_pend_k2", pending, 8'h20);
        tick();
        check("t1_valid_k3", {7'd0, irq_valid}, 8'h01);
        check("t1_id_k3",    {5'd0, irq_id},    8'h05);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("t1_pend_ack", pending, 8'h00);
        check("t1_valid_ack", {7'd0, irq_valid}, 8'h00);
        ticks(2);

        // No preemption: id 2 is held while line 7 pends.
        irq_req = 8'h04; tick(); irq_req = 8'h00;
        ticks(3);
        irq_req = 8'h80; tick(); irq_req = 8'h00;
        ticks(3);
        check("t2_hold_id", {5'd0, irq_id}, 8'h02);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);
        check("t2_next_valid", {7'd0, irq_valid}, 8'h01);
        check("t2_next_id",    {5'd0, irq_id},    8'h07);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);

        // Masked line stays pending and is presented once unmasked.
        irq_mask = 8'h7F;
        irq_req = 8'h80; tick(); irq_req = 8'h00;
        ticks(2);
        check("t3_pend",   pending, 8'h80);
        check("t3_enc_en", {7'd0, enc_en}, 8'h00);
        tick();
        check("t3_no_valid", {7'd0, irq_valid}, 8'h00);
        irq_mask = 8'hFF;
        tick();
        check("t3_unmask_id", {5'd0, irq_id}, 8'h07);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);

        // Set wins over clear: new rise on line 3 lands on the ack edge.
        irq_req = 8'h08; tick(); irq_req = 8'h00;
        ticks(3);
        irq_req = 8'h08; tick(); irq_req = 8'h00;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("t4_pend_kept", pending, 8'h08);
        ticks(2);
        check("t4_represent", {5'd0, irq_id}, 8'h03);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);

        // Spurious ack in IDLE, then async reset mid-BUSY.
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("t5_spurious", {7'd0, irq_valid}, 8'h00);
        irq_req = 8'h91; tick(); irq_req = 8'h00;
        ticks(3);
        check("t5_pend91", pending, 8'h91);
`else
        // Level mode: held request re-presents after ack, drops when released.
        irq_req = 8'h10;
        ticks(3);
        check("lv_id", {5'd0, irq_id}, 8'h04);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);
        check("lv_represent", {7'd0, irq_valid}, 8'h01);
        irq_req = 8'h00;
        ticks(2);
        check("lv_drop", pending, 8'h00);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);
        irq_req = 8'h91;
        ticks(3);
        irq_req = 8'h00;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_pend",  pending, 8'h00);
        check("rst_mid_valid", {7'd0, irq_valid}, 8'h00);
        check("rst_mid_id",    {5'd0, irq_id},    8'h00);
        check("rst_mid_enc",   enc_in, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Randomised traffic, including held and spurious acks and mask churn.
        for (int n = 0; n < 800; n++) begin
            r = $urandom & $urandom & $urandom;
            irq_req = r[7:0];
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom;
                irq_mask = r[7:0];
            end
            irq_ack = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
